// File: rtl/dlfloat_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dlfloat_pkg
// Brief   : Shared dlfloat16 constants and the dot-sequencer state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package dlfloat_pkg;

    localparam int DLF_W = 16;

    localparam logic [DLF_W-1:0] DLF_NAN  = 16'hFFFF;
    localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;

    typedef enum logic [3:0] {
        S_LEN    = 4'd0,
        S_A_LO   = 4'd1,
        S_A_HI   = 4'd2,
        S_B_LO   = 4'd3,
        S_B_HI   = 4'd4,
        S_ISSUE  = 4'd5,
        S_DRAIN  = 4'd6,
        S_OUT_HI = 4'd7,
        S_OUT_LO = 4'd8
    } state_t;

    // States that consume bytes from the upstream stream.
    function automatic logic takes_input(input state_t s);
        return (s == S_LEN) || (s == S_A_LO) || (s == S_A_HI) ||
               (s == S_B_LO) || (s == S_B_HI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dlfloat_out_serializer.sv
`default_nettype none
// ============================================================================
// Module  : dlfloat_out_serializer
// Brief   : Holds a 16-bit result and emits it MSB byte first over valid/ready.
// Revision: 1.0 - initial release
// ============================================================================
module dlfloat_out_serializer
    import dlfloat_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DLF_W-1:0] word,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [7:0] r_data;
    logic [7:0] r_lo;
    logic       r_valid;
    logic       r_second;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data   <= '0;
            r_lo     <= '0;
            r_valid  <= 1'b0;
            r_second <= 1'b0;
        end else if (load) begin
            r_data   <= word[15:8];
            r_lo     <= word[7:0];
            r_valid  <= 1'b1;
            r_second <= 1'b0;
        end else if (r_valid && out_ready) begin
            if (!r_second) begin
                r_data   <= r_lo;
                r_second <= 1'b1;
            end else begin
                r_data   <= '0;
                r_valid  <= 1'b0;
                r_second <= 1'b0;
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/dlfloat_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : dlfloat_dot_sequencer
// Brief   : Parses a length-prefixed byte stream of dlfloat16 operand pairs,
//           drives an external MAC and returns the 16-bit result as two bytes.
// Revision: 1.0 - initial release
// ============================================================================
module dlfloat_dot_sequencer
    import dlfloat_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int MAC_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DLF_W-1:0] mac_a,
    output logic [DLF_W-1:0] mac_b,
    output logic             mac_valid,
    output logic             mac_clear,
    input  logic [DLF_W-1:0] mac_result,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int N_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N_W-1:0]   r_n;
    logic [N_W-1:0]   w_len;
    logic [CNT_W-1:0] r_drain_cnt;
    logic [7:0]       r_a_lo;
    logic [7:0]       r_a_hi;
    logic [7:0]       r_b_lo;
    logic [DLF_W-1:0] r_mac_a;
    logic [DLF_W-1:0] r_mac_b;
    logic             r_mac_valid;
    logic             r_mac_clear;
    logic             r_in_ready;
    logic             r_busy;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_drain_done;
    logic             w_load;
    logic [DLF_W-1:0] w_load_word;

    assign w_in_xfer    = in_valid && r_in_ready;
    assign w_out_xfer   = out_valid && out_ready;
    assign w_drain_done = (r_drain_cnt == CNT_W'(MAC_LAT - 1));
    assign w_len        = ({24'd0, in_data} > MAX_LEN) ? N_W'(MAX_LEN) : N_W'(in_data);

    // The serializer is loaded on the same edge that enters S_OUT_HI so that
    // out_valid rises together with the state.
    assign w_load      = ((r_state == S_LEN) && w_in_xfer && (w_len == '0)) ||
                         ((r_state == S_DRAIN) && w_drain_done);
    assign w_load_word = (r_state == S_DRAIN) ? mac_result : DLF_ZERO;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LEN:    if (w_in_xfer) w_state_nxt = (w_len == '0) ? S_OUT_HI : S_A_LO;
            S_A_LO:   if (w_in_xfer) w_state_nxt = S_A_HI;
            S_A_HI:   if (w_in_xfer) w_state_nxt = S_B_LO;
            S_B_LO:   if (w_in_xfer) w_state_nxt = S_B_HI;
            S_B_HI:   if (w_in_xfer) w_state_nxt = S_ISSUE;
            S_ISSUE:  w_state_nxt = (r_n != N_W'(1)) ? S_A_LO : S_DRAIN;
            S_DRAIN:  if (w_drain_done) w_state_nxt = S_OUT_HI;
            S_OUT_HI: if (w_out_xfer) w_state_nxt = S_OUT_LO;
            S_OUT_LO: if (w_out_xfer) w_state_nxt = S_LEN;
            default:  w_state_nxt = S_LEN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_LEN;
            r_n         <= '0;
            r_drain_cnt <= '0;
            r_a_lo      <= '0;
            r_a_hi      <= '0;
            r_b_lo      <= '0;
            r_mac_a     <= '0;
            r_mac_b     <= '0;
            r_mac_valid <= 1'b0;
            r_mac_clear <= 1'b0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= takes_input(w_state_nxt);
            r_busy      <= (w_state_nxt != S_LEN);
            r_mac_valid <= (w_state_nxt == S_ISSUE);
            r_mac_clear <= (r_state == S_LEN) && w_in_xfer && (w_len != '0);
            r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 1'b1 : '0;

            if (w_in_xfer) begin
                case (r_state)
                    S_LEN:  r_n    <= w_len;
                    S_A_LO: r_a_lo <= in_data;
                    S_A_HI: r_a_hi <= in_data;
                    S_B_LO: r_b_lo <= in_data;
                    S_B_HI: begin
                        r_mac_a <= {r_a_hi, r_a_lo};
                        r_mac_b <= {in_data, r_b_lo};
                    end
                    default: ;
                endcase
            end

            if (r_state == S_ISSUE) r_n <= r_n - 1'b1;
        end
    end

    dlfloat_out_serializer u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load),
        .word      (w_load_word),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign mac_a     = r_mac_a;
    assign mac_b     = r_mac_b;
    assign mac_valid = r_mac_valid;
    assign mac_clear = r_mac_clear;

endmodule
`default_nettype wire

// File: tb/tb_dlfloat_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_dlfloat_dot_sequencer
// Brief   : Directed bench for dlfloat_dot_sequencer with a stub MAC result.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dlfloat_dot_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] mac_a;
    logic [15:0] mac_b;
    logic        mac_valid;
    logic        mac_clear;
    logic [15:0] mac_result;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor state: cumulative pulse counts and captured operand pairs.
    int          vcnt    = 0;
    int          ccnt    = 0;
    int          overlap = 0;
    logic [15:0] cap_a [0:63];
    logic [15:0] cap_b [0:63];

    dlfloat_dot_sequencer #(.MAX_LEN(16), .MAC_LAT(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_valid  (mac_valid),
        .mac_clear  (mac_clear),
        .mac_result (mac_result),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mac_valid && mac_clear) overlap++;
        if (mac_clear) ccnt++;
        if (mac_valid) begin
            if (vcnt < 64) begin
                cap_a[vcnt] = mac_a;
                cap_b[vcnt] = mac_b;
            end
            vcnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("send_timeout", 64'(t < 200), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input int gap);
        send_byte(a[7:0], gap);
        send_byte(a[15:8], gap);
        send_byte(b[7:0], gap);
        send_byte(b[15:8], gap);
    endtask

    task automatic recv_byte(output logic [7:0] b);
        int t = 0;
        out_ready = 1'b1;
        while (!out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("recv_timeout", 64'(t < 200), 64'd1);
        b = out_data;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0]  b0, b1;
        int          base_v, base_c, bad;
        logic [15:0] ea, eb;

        rst_n      = 1'b0;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        mac_result = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset_outputs", {in_ready, busy, mac_valid, mac_clear, out_valid,
                                mac_a, mac_b, out_data}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_in_ready", 64'(in_ready), 64'd1);
        check("post_reset_busy", 64'(busy), 64'd0);

        // Single element: A=3E00, B=4000, stub result 4000.
        base_v = vcnt; base_c = ccnt;
        mac_result = 16'h4000;
        send_byte(8'h01, 0);
        send_pair(16'h3E00, 16'h4000, 0);
        recv_byte(b0);
        recv_byte(b1);
        check("t1_clear_cnt", 64'(ccnt - base_v * 0 - base_c), 64'd1);
        check("t1_valid_cnt", 64'(vcnt - base_v), 64'd1);
        check("t1_mac_a", cap_a[base_v], 64'h3E00);
        check("t1_mac_b", cap_b[base_v], 64'h4000);
        check("t1_out_hi", b0, 64'h40);
        check("t1_out_lo", b1, 64'h00);

        // Zero length: no MAC activity, result 0000.
        base_v = vcnt; base_c = ccnt;
        mac_result = 16'h1234;
        send_byte(8'h00, 0);
        recv_byte(b0);
        check("t2_busy_after_first", 64'(busy), 64'd1);
        recv_byte(b1);
        check("t2_out_hi", b0, 64'h00);
        check("t2_out_lo", b1, 64'h00);
        check("t2_clear_cnt", 64'(ccnt - base_c), 64'd0);
        check("t2_valid_cnt", 64'(vcnt - base_v), 64'd0);
        check("t2_busy_low", 64'(busy), 64'd0);

        // Three elements with in_valid toggling every other cycle.
        base_v = vcnt; base_c = ccnt;
        mac_result = 16'h7777;
        send_byte(8'h03, 1);
        send_pair(16'h1111, 16'h2222, 1);
        send_pair(16'h3433, 16'h4544, 1);
        send_pair(16'h5655, 16'h6766, 1);
        recv_byte(b0);
        recv_byte(b1);
        check("t3_valid_cnt", 64'(vcnt - base_v), 64'd3);
        check("t3_clear_cnt", 64'(ccnt - base_c), 64'd1);
        check("t3_a0", cap_a[base_v],     64'h1111);
        check("t3_b0", cap_b[base_v],     64'h2222);
        check("t3_a1", cap_a[base_v + 1], 64'h3433);
        check("t3_b1", cap_b[base_v + 1], 64'h4544);
        check("t3_a2", cap_a[base_v + 2], 64'h5655);
        check("t3_b2", cap_b[base_v + 2], 64'h6766);
        check("t3_out", {b0, b1}, 64'h7777);

        // Downstream stall in S_OUT_HI while upstream offers a byte.
        mac_result = 16'hABCD;
        send_byte(8'h01, 0);
        send_pair(16'h0102, 16'h0304, 0);
        begin
            int t = 0;
            while (!out_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
            check("t4_out_valid", 64'(out_valid), 64'd1);
        end
        in_data  = 8'h55;
        in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_data !== 8'hAB || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("t4_stall_stable", 64'(bad), 64'd0);
        recv_byte(b0);
        recv_byte(b1);
        check("t4_out", {b0, b1}, 64'hABCD);
        check("t4_idle_after", 64'(busy), 64'd0);

        // Reset after two operand bytes discards the partial vector.
        send_byte(8'h03, 0);
        send_byte(8'hEE, 0);
        send_byte(8'hDD, 0);
        rst_n = 1'b0;
        #1;
        check("t5_reset_outputs", {in_ready, busy, mac_valid, mac_clear, out_valid,
                                   mac_a, mac_b, out_data}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_in_ready", 64'(in_ready), 64'd1);
        base_v = vcnt; base_c = ccnt;
        mac_result = 16'h0102;
        send_byte(8'h02, 0);
        send_pair(16'hA001, 16'hB002, 0);
        send_pair(16'hC003, 16'hD004, 0);
        recv_byte(b0);
        recv_byte(b1);
        check("t5_valid_cnt", 64'(vcnt - base_v), 64'd2);
        check("t5_a0", cap_a[base_v], 64'hA001);
        check("t5_b1", cap_b[base_v + 1], 64'hD004);
        check("t5_out", {b0, b1}, 64'h0102);

        // Length 0xFF saturates to 16; NaN result forwarded untouched.
        base_v = vcnt; base_c = ccnt;
        mac_result = 16'hFFFF;
        send_byte(8'hFF, 0);
        for (int i = 0; i < 16; i++) send_pair(16'h3C00 + 16'(i), 16'h4100 + 16'(i * 3), 0);
        recv_byte(b0);
        recv_byte(b1);
        check("t6_valid_cnt", 64'(vcnt - base_v), 64'd16);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            ea = 16'h3C00 + 16'(i);
            eb = 16'h4100 + 16'(i * 3);
            if (base_v + i < 64 && (cap_a[base_v + i] !== ea || cap_b[base_v + i] !== eb)) bad++;
        end
        check("t6_pairs", 64'(bad), 64'd0);
        check("t6_out", {b0, b1}, 64'hFFFF);

        check("clear_valid_overlap", 64'(overlap), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dlfloat_dot_sequencer.md
DLFLOAT_DOT_SEQUENCER -- requirements
Module: dlfloat_dot_sequencer

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 16: the maximum vector length accepted.
REQ-002 The block SHALL have parameter MAC_LAT, default 2: the cycles from a mac_valid pulse until that product is reflected in mac_result.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_data, input, 8 bits: the upstream byte stream.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a byte.
REQ-008 The block SHALL have ports mac_a and mac_b, outputs, 16 bits each: the dlfloat16 operands to the MAC.
REQ-009 The block SHALL have port mac_valid, output, 1 bit: a one-cycle operand-issue strobe.
REQ-010 The block SHALL have port mac_clear, output, 1 bit: a one-cycle strobe that zeroes the MAC accumulator.
REQ-011 The block SHALL have port mac_result, input, 16 bits: the MAC accumulator value.
REQ-012 The block SHALL have port out_data, output, 8 bits: the result byte.
REQ-013 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-014 The block SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-015 The block SHALL have port busy, output, 1 bit: high in every state except S_LEN.

Function
REQ-016 A byte transfer SHALL occur only on a clk edge where in_valid=1 and in_ready=1; out transfer likewise with out_valid and out_ready.
REQ-017 The FSM SHALL step through S_LEN, S_A_LO, S_A_HI, S_B_LO, S_B_HI, S_ISSUE, S_DRAIN, S_OUT_HI, S_OUT_LO; each S_A_*/S_B_* state advances only on a byte transfer.
REQ-018 in_ready SHALL be 1 only in S_LEN, S_A_LO, S_A_HI, S_B_LO and S_B_HI; input bytes offered in any other state SHALL be ignored and not consumed.
REQ-019 In S_LEN, the accepted byte SHALL set the remaining count N, saturated to MAX_LEN; the count width is clog2(MAX_LEN+1).
REQ-020 Accepting N>=1 SHALL pulse mac_clear for exactly the next cycle and go to S_A_LO.
REQ-021 Accepting N=0 SHALL skip the MAC entirely: result=16'h0000, go to S_OUT_HI, and issue no mac_clear.
REQ-022 Operand bytes SHALL arrive low byte first, A then B; mac_a and mac_b SHALL hold the assembled values from S_ISSUE until the next S_ISSUE.
REQ-023 S_ISSUE SHALL last exactly 1 cycle, with mac_valid=1 and N decremented.
REQ-024 S_ISSUE SHALL go to S_A_LO if the decremented N is nonzero, else to S_DRAIN.
REQ-025 S_DRAIN SHALL last exactly MAC_LAT cycles, then register mac_result as the result and go to S_OUT_HI.
REQ-026 S_OUT_HI SHALL present result[15:8] and S_OUT_LO SHALL present result[7:0].
REQ-027 out_valid SHALL be 1 in both output states, with out_data held stable until the transfer.
REQ-028 A transfer in S_OUT_LO SHALL return the FSM to S_LEN.
REQ-029 A result of 16'hFFFF (NaN) SHALL be forwarded unchanged, with no special handling.
REQ-030 mac_clear and mac_valid SHALL never be high in the same cycle.

Reset
REQ-031 While rst_n=0, the block SHALL hold state=S_LEN, N=0, result=0 and all outputs 0.
REQ-032 A reset mid-vector or mid-output SHALL discard all partial operands and the result.
REQ-033 After reset, the first accepted byte SHALL be treated as a length byte.

Structure
REQ-034 Shared package dlfloat_pkg SHALL hold the FSM state enum, the DLF_NAN=16'hFFFF and DLF_ZERO=16'h0000 constants, and the 16-bit dlfloat width.
REQ-035 The output stage SHALL be implemented as sub-module dlfloat_out_serializer: a 16-to-8 MSB-first serializer with a valid/ready handshake.

Verification
REQ-036 N=1, A=3E00, B=4000, stub mac_result=4000 → one mac_clear, then one mac_valid with mac_a=3E00 and mac_b=4000; out bytes 40 then 00.
REQ-037 N=0 → no mac_clear and no mac_valid; out bytes 00, 00; busy returns low after the second transfer.
REQ-038 N=3 with in_valid toggling every other cycle → exactly 3 mac_valid pulses, each with the correct operand pair, and no byte lost.
REQ-039 out_ready held 0 for 10 cycles in S_OUT_HI → out_data=high byte stable, and in_ready=0 throughout.
REQ-040 rst_n pulsed low after 2 operand bytes → all outputs 0, in_ready=1; the next byte 02 starts a 2-element vector.
REQ-041 Length byte 0xFF with MAX_LEN=16 → exactly 16 mac_valid pulses; stub result FFFF → out bytes FF, FF.
